// File: rtl/param_mux_scanner.sv
// N-channel registered mux with manual select or auto-scan and a one-entry ready/valid output.
// Optional MUX_PARITY_EN registers even parity of each loaded word on par.
module param_mux_scanner #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  din,
  input  logic [SW-1:0]   sel,
  input  logic            mode,
  input  logic            en,
  input  logic            out_ready,
  output logic [W-1:0]    dout,
  output logic [SW-1:0]   ch,
  output logic            out_valid,
  output logic            err,
  output logic            par
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [SW-1:0] LAST = SW'(N - 1);

  state_t          state, state_nxt;
  logic            load;
  logic [SW-1:0]   idx;
  logic            idx_ok;
  logic [W-1:0]    load_data;
  logic [SW-1:0]   scan_cnt;

  always_comb begin
    load      = en && ((state == EMPTY) || out_ready);
    idx       = mode ? scan_cnt : sel;
    idx_ok    = 1'b0;
    load_data = '0;
    // out-of-range selects fall through the loop and load zero with err set
    for (int unsigned k = 0; k < N; k++) begin
      if (idx == SW'(k)) begin
        idx_ok    = 1'b1;
        load_data = din[k*W +: W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (out_ready && !en) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout     <= '0;
      ch       <= '0;
      err      <= 1'b0;
      scan_cnt <= '0;
    end else if (load) begin
      dout <= load_data;
      ch   <= idx;
      err  <= !idx_ok;
      if (mode) scan_cnt <= (scan_cnt == LAST) ? '0 : scan_cnt + 1'b1;
    end
  end

  assign out_valid = (state == FULL);

`ifdef MUX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       par <= 1'b0;
    else if (load) par <= ^load_data;
  end
`else
  assign par = 1'b0;
`endif

endmodule

// File: tb/tb_param_mux_scanner.sv
// Directed bench: N=4 instance for main function, N=3 instance for out-of-range select.
module tb_param_mux_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_din;
  logic [1:0]  a_sel;
  logic        a_mode, a_en, a_ready;
  logic [7:0]  a_dout;
  logic [1:0]  a_ch;
  logic        a_valid, a_err, a_par;

  logic [23:0] b_din;
  logic [1:0]  b_sel;
  logic        b_mode, b_en, b_ready;
  logic [7:0]  b_dout;
  logic [1:0]  b_ch;
  logic        b_valid, b_err, b_par;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_par1;

  always #5 clk = ~clk;

  param_mux_scanner #(.W(8), .N(4), .SW(2)) u_a (
    .clk(clk), .rst(rst), .din(a_din), .sel(a_sel), .mode(a_mode), .en(a_en),
    .out_ready(a_ready), .dout(a_dout), .ch(a_ch), .out_valid(a_valid),
    .err(a_err), .par(a_par)
  );

  param_mux_scanner #(.W(8), .N(3), .SW(2)) u_b (
    .clk(clk), .rst(rst), .din(b_din), .sel(b_sel), .mode(b_mode), .en(b_en),
    .out_ready(b_ready), .dout(b_dout), .ch(b_ch), .out_valid(b_valid),
    .err(b_err), .par(b_par)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [7:0] d, input logic [1:0] c,
                         input logic v, input logic e);
    check({tag, ".dout"}, 32'(a_dout), 32'(d));
    check({tag, ".ch"}, 32'(a_ch), 32'(c));
    check({tag, ".valid"}, 32'(a_valid), 32'(v));
    check({tag, ".err"}, 32'(a_err), 32'(e));
  endtask

  initial begin
`ifdef MUX_PARITY_EN
    exp_par1 = 1'b1;
`else
    exp_par1 = 1'b0;
`endif
    rst = 1'b1;
    a_din = 32'h44332211; a_sel = 2'd0; a_mode = 1'b1; a_en = 1'b1; a_ready = 1'b1;
    b_din = 24'h332211;   b_sel = 2'd0; b_mode = 1'b0; b_en = 1'b0; b_ready = 1'b1;
    #1;
    check_a("reset", 8'h00, 2'd0, 1'b0, 1'b0);
    check("reset.par", 32'(a_par), 32'd0);
    check("reset_b.valid", 32'(b_valid), 32'd0);
    #1 rst = 1'b0;

    // auto-scan from reset, back-to-back with out_ready held high
    tick(); check_a("auto0", 8'h11, 2'd0, 1'b1, 1'b0);
    tick(); check_a("auto1", 8'h22, 2'd1, 1'b1, 1'b0);
    tick(); check_a("auto2", 8'h33, 2'd2, 1'b1, 1'b0);
    tick(); check_a("auto3", 8'h44, 2'd3, 1'b1, 1'b0);
    tick(); check_a("auto4", 8'h11, 2'd0, 1'b1, 1'b0);
    tick(); check_a("auto5", 8'h22, 2'd1, 1'b1, 1'b0);
    // scan_cnt now 2

    a_mode = 1'b0; a_sel = 2'd2;
    tick(); check_a("manual2", 8'h33, 2'd2, 1'b1, 1'b0);

    a_sel = 2'd1;
    tick(); check_a("manual1", 8'h22, 2'd1, 1'b1, 1'b0);

    // stall: inputs churn, everything holds
    a_ready = 1'b0; a_mode = 1'b1; a_din = 32'hA4A3A2A1; a_sel = 2'd3;
    tick(); check_a("stall0", 8'h22, 2'd1, 1'b1, 1'b0);
    a_sel = 2'd0; a_mode = 1'b0;
    tick(); check_a("stall1", 8'h22, 2'd1, 1'b1, 1'b0);
    a_sel = 2'd2; a_din = 32'hA4A3A2A1;
    tick(); check_a("stall2", 8'h22, 2'd1, 1'b1, 1'b0);

    a_ready = 1'b1; a_en = 1'b0;
    tick(); check_a("drain", 8'h22, 2'd1, 1'b0, 1'b0);
    tick(); check_a("empty_hold", 8'h22, 2'd1, 1'b0, 1'b0);

    // scan resumes at held scan_cnt=2
    a_en = 1'b1; a_mode = 1'b1;
    tick(); check_a("resume2", 8'hA3, 2'd2, 1'b1, 1'b0);
    a_mode = 1'b0; a_sel = 2'd0;
    tick(); check_a("man0", 8'hA1, 2'd0, 1'b1, 1'b0);
    a_mode = 1'b1;
    tick(); check_a("resume3", 8'hA4, 2'd3, 1'b1, 1'b0);
    tick(); check_a("wrap0", 8'hA1, 2'd0, 1'b1, 1'b0);

    // async reset between edges while FULL
    #2 rst = 1'b1;
    #1 check_a("async_rst", 8'h00, 2'd0, 1'b0, 1'b0);
    check("async_rst.par", 32'(a_par), 32'd0);
    #1 rst = 1'b0;
    tick(); check_a("post_rst", 8'hA1, 2'd0, 1'b1, 1'b0);

    // parity
    a_mode = 1'b0; a_din = 32'h00000307; a_sel = 2'd0;
    tick(); check("par07.dout", 32'(a_dout), 32'h07);
    check("par07", 32'(a_par), 32'(exp_par1));
    a_sel = 2'd1;
    tick(); check("par03.dout", 32'(a_dout), 32'h03);
    check("par03", 32'(a_par), 32'd0);

    // out-of-range select on the N=3 instance
    b_en = 1'b1; b_sel = 2'd3;
    tick();
    check("oor.dout", 32'(b_dout), 32'h00);
    check("oor.ch", 32'(b_ch), 32'd3);
    check("oor.err", 32'(b_err), 32'd1);
    check("oor.valid", 32'(b_valid), 32'd1);
    b_sel = 2'd0;
    tick();
    check("inrange.dout", 32'(b_dout), 32'h11);
    check("inrange.ch", 32'(b_ch), 32'd0);
    check("inrange.err", 32'(b_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
